crypto_round_ctrl: RTL

Sequencing controller for the cryptochip hash datapath. Accepts 32-bit message words over a valid/ready stream and writes them into the compression core's block buffer. It then steps the core through a fixed number of rounds per block and presents a digest-ready handshake after the final block of a message. It sits between the message input port and the round/compression core.

---
 rtl/crypto_ctrl_pkg.sv | 14 +
 rtl/crypto_round_ctrl_zero_cmp.sv | 11 +
 rtl/crypto_round_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/crypto_ctrl_pkg.sv
// Shared types and widths for the hash sequencing controller.
// The optional CRYPTO_CTRL_BITLEN_EN feature is handled in crypto_round_ctrl.sv.
package crypto_ctrl_pkg;

    localparam int unsigned MSG_W = 32;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ROUND = 2'd1,
        HOLD  = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/crypto_round_ctrl_zero_cmp.sv
// Final-round detect: flags when the round down-counter has reached zero.
module ZeroComparator_0x422b1f52edd46a85
    import crypto_ctrl_pkg::*;
(
    input  logic [CNT_W-1:0] value,
    output logic             is_zero
);

    assign is_zero = (value == '0);

endmodule

// File: rtl/crypto_round_ctrl.sv
// Loads WORDS message words per block, steps the core through ROUNDS rounds, then
// holds a digest handshake after the final block. Define CRYPTO_CTRL_BITLEN_EN for msg_bits.
module crypto_round_ctrl
    import crypto_ctrl_pkg::*;
#(
    parameter int unsigned WORDS  = 16,
    parameter int unsigned ROUNDS = 64,
    parameter int unsigned IDX_W  = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             msg_val,
    output logic             msg_rdy,
    input  logic [MSG_W-1:0] msg,
    input  logic             msg_last,
    output logic             wr_en,
    output logic [IDX_W-1:0] wr_idx,
    output logic [MSG_W-1:0] wr_data,
    output logic             core_init,
    output logic             round_en,
    output logic [CNT_W-1:0] rnd_idx,
    output logic             dig_val,
    input  logic             dig_rdy,
    output logic             busy,
    output logic [1:0]       dbg_state
`ifdef CRYPTO_CTRL_BITLEN_EN
    ,
    output logic [63:0]      msg_bits
`endif
);

    // Handshakes: a word transfers on msg_val & msg_rdy, the digest on dig_val & dig_rdy,
    // both at the rising edge; valid may not depend on ready.

    localparam logic [IDX_W-1:0] WCNT_MAX  = IDX_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] RCNT_INIT = CNT_W'(ROUNDS - 1);

    ctrl_state_e      state_q, state_d;
    logic [IDX_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic             first_q, first_d;
    logic             last_q, last_d;

    logic in_load;
    logic in_round;
    logic in_hold;
    logic accept;
    logic dig_accept;
    logic rcnt_zero;

    ZeroComparator_0x422b1f52edd46a85 u_zero_cmp (
        .value   (rcnt_q),
        .is_zero (rcnt_zero)
    );

    assign in_load    = (state_q == LOAD);
    assign in_round   = (state_q == ROUND);
    assign in_hold    = (state_q == HOLD);
    assign accept     = in_load & msg_val;
    assign dig_accept = in_hold & dig_rdy;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        rcnt_d  = rcnt_q;
        first_d = first_q;
        last_d  = last_q;
        case (state_q)
            LOAD: begin
                if (accept) begin
                    wcnt_d = wcnt_q + IDX_W'(1);
                    if (wcnt_q == WCNT_MAX) begin
                        last_d  = msg_last;
                        rcnt_d  = RCNT_INIT;
                        wcnt_d  = '0;
                        state_d = ROUND;
                    end
                end
            end
            ROUND: begin
                rcnt_d = rcnt_q - CNT_W'(1);
                if (rcnt_zero) begin
                    first_d = 1'b0;
                    state_d = last_q ? HOLD : LOAD;
                end
            end
            HOLD: begin
                if (dig_rdy) begin
                    first_d = 1'b1;
                    last_d  = 1'b0;
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LOAD;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            first_q <= 1'b1;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    // Round number counts up while the counter counts down; forced to 0 outside ROUND.
    assign msg_rdy   = in_load;
    assign wr_en     = accept;
    assign wr_idx    = wcnt_q;
    assign wr_data   = msg;
    assign round_en  = in_round;
    assign rnd_idx   = in_round ? (RCNT_INIT - rcnt_q) : '0;
    assign core_init = in_round & first_q & (rcnt_q == RCNT_INIT);
    assign dig_val   = in_hold;
    assign busy      = in_round | in_hold;
    assign dbg_state = state_q;

`ifdef CRYPTO_CTRL_BITLEN_EN
    logic [63:0] bits_q, bits_d;

    always_comb begin
        bits_d = bits_q;
        if (dig_accept) begin
            bits_d = '0;
        end else if (accept) begin
            bits_d = bits_q + 64'd32;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bits_q <= '0;
        end else begin
            bits_q <= bits_d;
        end
    end

    assign msg_bits = bits_q;
`else
    logic unused_dig_accept;
    assign unused_dig_accept = dig_accept;
`endif

endmodule
